// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } life_state_e;

    // Conway B3/S23 rule masks: bit n selects the outcome for n live neighbours.
    localparam logic [8:0] DEF_BIRTH   = 9'b000001000;
    localparam logic [8:0] DEF_SURVIVE = 9'b000001100;

    localparam int GEN_W = 16;

endpackage

// File: rtl/life_rule.sv
// Next-state rule for one cell: cells[4] is the centre, the other eight bits are its neighbours.
module life_rule
    import life_pkg::*;
(
    input  logic [8:0] cells,
    input  logic [8:0] birth,
    input  logic [8:0] survive,
    output logic       next
);

    logic [3:0] n;

    always_comb begin
        n = 4'(cells[0]) + 4'(cells[1]) + 4'(cells[2]) + 4'(cells[3])
          + 4'(cells[5]) + 4'(cells[6]) + 4'(cells[7]) + 4'(cells[8]);
        next = cells[4] ? survive[n] : birth[n];
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life grid engine: serial one-cell-per-cycle generation into a shadow grid, then one-cycle commit.
// Define LIFE_WRAP_EN for a toroidal grid; otherwise off-grid neighbours read as dead.
module life_engine
    import life_pkg::*;
#(
    parameter int         X       = 8,
    parameter int         Y       = 8,
    parameter int         LOG2X   = 3,
    parameter int         LOG2Y   = 3,
    parameter logic [8:0] BIRTH   = DEF_BIRTH,
    parameter logic [8:0] SURVIVE = DEF_SURVIVE,
    parameter int         PERIOD  = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_nxt,
    input  logic             key_run,
    input  logic             key_flip,
    input  logic             key_clr,
    input  logic [LOG2X-1:0] cursor_x,
    input  logic [LOG2Y-1:0] cursor_y,
    output logic [X*Y-1:0]   data,
    output logic             busy,
    output logic             running,
    output logic [GEN_W-1:0] gen_cnt
);

    localparam int N  = X * Y;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);

    life_state_e      state_q, state_d;
    logic [N-1:0]     shadow;
    logic [LOG2X-1:0] cx;
    logic [LOG2Y-1:0] cy;
    logic [TW-1:0]    timer;
    logic             nxt_pend;

    logic             edit, timer_hit, gen_req, start, defer, last;
    logic             flip_ok;
    logic [IW-1:0]    flip_idx, scan_idx;
    logic [8:0]       cells;
    logic             next_cell;

    function automatic logic cell_at(input logic [N-1:0] g, input int px, input int py);
        int qx, qy;
        qx = px;
        qy = py;
`ifdef LIFE_WRAP_EN
        if (qx < 0) qx = qx + X;
        else if (qx >= X) qx = qx - X;
        if (qy < 0) qy = qy + Y;
        else if (qy >= Y) qy = qy - Y;
`else
        if (qx < 0 || qx >= X || qy < 0 || qy >= Y) return 1'b0;
`endif
        return g[IW'(qy * X + qx)];
    endfunction

    // Neighbourhood of the scan cursor, always read from the committed grid.
    assign cells = {
        cell_at(data, int'(cx) + 1, int'(cy) + 1),
        cell_at(data, int'(cx),     int'(cy) + 1),
        cell_at(data, int'(cx) - 1, int'(cy) + 1),
        cell_at(data, int'(cx) + 1, int'(cy)),
        cell_at(data, int'(cx),     int'(cy)),
        cell_at(data, int'(cx) - 1, int'(cy)),
        cell_at(data, int'(cx) + 1, int'(cy) - 1),
        cell_at(data, int'(cx),     int'(cy) - 1),
        cell_at(data, int'(cx) - 1, int'(cy) - 1)
    };

    life_rule u_rule (
        .cells   (cells),
        .birth   (BIRTH),
        .survive (SURVIVE),
        .next    (next_cell)
    );

    assign scan_idx = IW'(int'(cy) * X + int'(cx));
    assign flip_idx = IW'(int'(cursor_y) * X + int'(cursor_x));
    assign flip_ok  = (int'(cursor_x) < X) && (int'(cursor_y) < Y);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A start that coincides with a grid edit is deferred one cycle so the edit lands first.
    always_comb begin
        state_d   = state_q;
        edit      = key_clr | key_flip;
        timer_hit = running && (timer == '0);
        gen_req   = key_nxt | timer_hit | nxt_pend;
        start     = 1'b0;
        defer     = 1'b0;
        last      = (int'(cx) == X - 1) && (int'(cy) == Y - 1);
        case (state_q)
            IDLE: begin
                start = gen_req & ~edit;
                defer = gen_req & edit;
                if (start) state_d = SCAN;
            end
            SCAN:    if (last) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            timer   <= '0;
        end else if (key_run) begin
            running <= ~running;
            timer   <= RELOAD;
        end else if (running && state_q == IDLE) begin
            if (gen_req) timer <= RELOAD;
            else         timer <= timer - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= '0;
            shadow   <= '0;
            gen_cnt  <= '0;
            cx       <= '0;
            cy       <= '0;
            nxt_pend <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    nxt_pend <= defer;
                    cx       <= '0;
                    cy       <= '0;
                    if (key_clr)                 data           <= '0;
                    else if (key_flip && flip_ok) data[flip_idx] <= ~data[flip_idx];
                end
                SCAN: begin
                    shadow[scan_idx] <= next_cell;
                    if (int'(cx) == X - 1) begin
                        cx <= '0;
                        cy <= cy + LOG2Y'(1);
                    end else begin
                        cx <= cx + LOG2X'(1);
                    end
                end
                COMMIT: begin
                    data    <= shadow;
                    gen_cnt <= gen_cnt + GEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine (8x8, PERIOD=20) with a scoreboard of expected committed grids.
module tb_life_engine;

    logic        clk = 1'b0;
    logic        rst, key_nxt, key_run, key_flip, key_clr;
    logic [2:0]  cursor_x, cursor_y;
    logic [63:0] data;
    logic        busy, running;
    logic [15:0] gen_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model;

    always #5 clk = ~clk;

    life_engine #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .PERIOD(20)) dut (
        .clk(clk), .rst(rst), .key_nxt(key_nxt), .key_run(key_run),
        .key_flip(key_flip), .key_clr(key_clr), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .data(data), .busy(busy), .running(running), .gen_cnt(gen_cnt)
    );

    // Independent B3/S23 reference model.
    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] r;
        int n, nx, ny;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            nx = x + dx;
                            ny = y + dy;
`ifdef LIFE_WRAP_EN
                            nx = (nx + 8) % 8;
                            ny = (ny + 8) % 8;
                            n += int'(g[ny*8+nx]);
`else
                            if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8) n += int'(g[ny*8+nx]);
`endif
                        end
                    end
                end
                if (g[y*8+x]) r[y*8+x] = (n == 2 || n == 3);
                else          r[y*8+x] = (n == 3);
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model = '0;
        exp_q.delete();
        tick();
    endtask

    task automatic flip_cell(input int x, input int y);
        cursor_x = 3'(x);
        cursor_y = 3'(y);
        key_flip = 1'b1;
        tick();
        key_flip = 1'b0;
        model[y*8+x] = ~model[y*8+x];
    endtask

    task automatic start_gen;
        exp_q.push_back(life_step(model));
        model = life_step(model);
        key_nxt = 1'b1;
        tick();
        key_nxt = 1'b0;
    endtask

    task automatic finish_gen(input string name, input int exp_busy);
        int cnt;
        logic [63:0] exp;
        cnt = 0;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, cnt, exp_busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty got=commit exp=no_commit", name);
        end else begin
            exp = exp_q.pop_front();
            if (data !== exp) begin
                errors++;
                $display("FAIL %s_data got=%h exp=%h", name, data, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++; if (data !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (gen_cnt !== 16'd0) begin errors++; $display("FAIL reset_gen_cnt got=%0d exp=0", gen_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_blinker;
        logic [63:0] want;
        apply_reset();
        flip_cell(2, 3); flip_cell(3, 3); flip_cell(4, 3);
        want = '0; want[26] = 1'b1; want[27] = 1'b1; want[28] = 1'b1;
        checks++; if (data !== want) begin errors++; $display("FAIL flip_data got=%h exp=%h", data, want); end
        start_gen();
        finish_gen("blinker", 65);
        want = '0; want[19] = 1'b1; want[27] = 1'b1; want[35] = 1'b1;
        checks++; if (data !== want) begin errors++; $display("FAIL blinker_vertical got=%h exp=%h", data, want); end
        checks++; if (gen_cnt !== 16'd1) begin errors++; $display("FAIL blinker_gen_cnt got=%0d exp=1", gen_cnt); end
    endtask

    task automatic test_block;
        logic [63:0] want;
        apply_reset();
        flip_cell(0, 0); flip_cell(1, 0); flip_cell(0, 1); flip_cell(1, 1);
        want = 64'h0303;
        for (int i = 0; i < 3; i++) begin
            start_gen();
            finish_gen("block", 65);
        end
        checks++; if (data !== want) begin errors++; $display("FAIL block_still got=%h exp=%h", data, want); end
        checks++; if (gen_cnt !== 16'd3) begin errors++; $display("FAIL block_gen_cnt got=%0d exp=3", gen_cnt); end
    endtask

    task automatic test_corner;
        logic [63:0] want;
        apply_reset();
        flip_cell(0, 0); flip_cell(7, 0); flip_cell(0, 7);
        start_gen();
        finish_gen("corner", 65);
`ifdef LIFE_WRAP_EN
        want = '0; want[0] = 1'b1; want[7] = 1'b1; want[56] = 1'b1; want[63] = 1'b1;
`else
        want = '0;
`endif
        checks++; if (data !== want) begin errors++; $display("FAIL corner_edge got=%h exp=%h", data, want); end
    endtask

    task automatic test_drop_keys;
        int idle_starts;
        apply_reset();
        flip_cell(2, 3); flip_cell(3, 3); flip_cell(4, 3);
        start_gen();
        repeat (10) tick();
        cursor_x = 3'd3; cursor_y = 3'd3;
        key_flip = 1'b1; key_nxt = 1'b1;
        tick();
        key_flip = 1'b0; key_nxt = 1'b0;
        finish_gen("drop_flip", 54);
        idle_starts = 0;
        repeat (5) begin
            tick();
            if (busy) idle_starts++;
        end
        checks++; if (idle_starts !== 0) begin errors++; $display("FAIL drop_nxt busy_cycles=%0d exp=0", idle_starts); end
        checks++; if (gen_cnt !== 16'd1) begin errors++; $display("FAIL drop_gen_cnt got=%0d exp=1", gen_cnt); end
    endtask

    task automatic test_clr_flip;
        cursor_x = 3'd0; cursor_y = 3'd0;
        key_clr = 1'b1; key_flip = 1'b1;
        tick();
        key_clr = 1'b0; key_flip = 1'b0;
        model = '0;
        checks++; if (data !== 64'h0) begin errors++; $display("FAIL clr_flip_data got=%h exp=0", data); end
        checks++; if (gen_cnt !== 16'd1) begin errors++; $display("FAIL clr_gen_cnt got=%0d exp=1", gen_cnt); end
        flip_cell(5, 5);
        cursor_x = 3'd2; cursor_y = 3'd2;
        key_clr = 1'b1; key_flip = 1'b1; key_nxt = 1'b1;
        tick();
        key_clr = 1'b0; key_flip = 1'b0; key_nxt = 1'b0;
        model = '0;
        checks++; if (busy !== 1'b0 || data !== 64'h0) begin errors++; $display("FAIL clr_nxt_first busy=%b data=%h exp busy=0 data=0", busy, data); end
        exp_q.push_back(life_step(model));
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_nxt_deferred busy=%b exp=1", busy); end
        finish_gen("clr_nxt", 65);
        checks++; if (gen_cnt !== 16'd2) begin errors++; $display("FAIL clr_nxt_gen_cnt got=%0d exp=2", gen_cnt); end
    endtask

    task automatic test_run;
        int cnt, late;
        apply_reset();
        flip_cell(2, 3); flip_cell(3, 3); flip_cell(4, 3);
        exp_q.push_back(life_step(model));
        exp_q.push_back(life_step(life_step(model)));
        key_run = 1'b1;
        tick();
        key_run = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_on got=%b exp=1", running); end
        cnt = 0;
        while (!busy && cnt < 100) begin tick(); cnt++; end
        checks++; if (cnt !== 20) begin errors++; $display("FAIL run_first_start got=%0d exp=20", cnt); end
        finish_gen("run_gen1", 65);
        cnt = 0;
        while (!busy && cnt < 100) begin tick(); cnt++; end
        checks++; if (cnt !== 20) begin errors++; $display("FAIL run_repeat got=%0d exp=20", cnt); end
        key_run = 1'b1;
        tick();
        key_run = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_off got=%b exp=0", running); end
        finish_gen("run_gen2", 64);
        late = 0;
        repeat (100) begin
            tick();
            if (busy) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL run_stopped busy_cycles=%0d exp=0", late); end
        checks++; if (gen_cnt !== 16'd2) begin errors++; $display("FAIL run_gen_cnt got=%0d exp=2", gen_cnt); end
    endtask

    task automatic test_rst_mid_scan;
        apply_reset();
        flip_cell(2, 3); flip_cell(3, 3); flip_cell(4, 3);
        start_gen();
        repeat (30) tick();
        rst = 1'b1;
        #1;
        checks++; if (data !== 64'h0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (gen_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_gen_cnt got=%0d exp=0", gen_cnt); end
        rst = 1'b0;
        exp_q.delete();
        model = '0;
        repeat (70) tick();
        checks++; if (data !== 64'h0 || gen_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_no_commit data=%h gen_cnt=%0d exp 0/0", data, gen_cnt); end
    endtask

    initial begin
        rst = 1'b0; key_nxt = 1'b0; key_run = 1'b0; key_flip = 1'b0; key_clr = 1'b0;
        cursor_x = '0; cursor_y = '0; model = '0;
        #2;
        test_reset();
        test_blinker();
        test_block();
        test_corner();
        test_drop_keys();
        test_clr_flip();
        test_run();
        test_rst_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
